// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, data width, FSM encoding and
// the baud divisor calculation used by both transmitter and receiver.
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int DATA_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int calc_divisor(input int clk_hz, input int baud);
      return clk_hz / (baud * OVERSAMPLE);
   endfunction
endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake of the UART transmitter (valid/ready plus enable).
interface uart_tx_if;
   import uart_pkg::*;

   logic              tx_en;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;

   modport master (output tx_en, output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_en, input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running DIVISOR counter producing a one-clock 16x oversample tick.
// tick_nxt_o predicts the tick one clock ahead (assuming no clear).
module uart_baud_gen #(
   parameter int DIVISOR = 651
) (
   input  logic clk,
   input  logic arst_n,
   input  logic clr_i,
   output logic tick_o,
   output logic tick_nxt_o
);
   localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);
   localparam logic [CNT_W-1:0] PRE  = CNT_W'((DIVISOR > 1) ? DIVISOR - 2 : 0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign cnt_d = (clr_i || cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o     = (cnt_q == LAST);
   assign tick_nxt_o = (DIVISOR == 1) ? 1'b1 : (cnt_q == PRE);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1, MSB first, 16x oversampled bit timing, with a
// one-byte holding register so consecutive frames run without an idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int UART_INPUT_CLK = 100_000_000,
   parameter int baud_rate      = 9600
) (
   input  logic     clk,
   input  logic     arst_n,
   uart_tx_if.slave bus,
   output logic     tx,
   output logic     busy,
   output logic     done
);
   localparam int DIVISOR = calc_divisor(UART_INPUT_CLK, baud_rate);

   uart_state_e       state_q;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] shift_q;
   logic              hold_full_q;
   logic              tx_q;
   logic              busy_q;
   logic              done_q;
   logic [3:0]        os_q;
   logic [3:0]        os_d;
   logic [2:0]        idx_q;

   logic tick;
   logic tick_nxt;
   logic bit_end;
   logic start_frame;
   logic accept;

   uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
      .clk       (clk),
      .arst_n    (arst_n),
      .clr_i     (start_frame),
      .tick_o    (tick),
      .tick_nxt_o(tick_nxt)
   );

   assign bus.tx_ready = bus.tx_en & ~hold_full_q;
   assign accept       = bus.tx_valid & bus.tx_ready;
   assign bit_end      = tick & (os_q == 4'd15);
   assign os_d         = tick ? os_q + 4'd1 : os_q;
   // A held byte starts a frame from IDLE or straight out of a finishing stop bit.
   assign start_frame  = hold_full_q & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

   always_ff @(posedge clk) begin
      if (accept)      hold_q  <= bus.tx_data;
      if (start_frame) shift_q <= hold_q;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         os_q        <= '0;
         idx_q       <= '0;
      end else begin
         done_q <= 1'b0;
         os_q   <= os_d;
         if (accept) hold_full_q <= 1'b1;
         if (start_frame) begin
            state_q     <= START;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
            os_q        <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
               START: if (bit_end) begin
                  state_q <= DATA;
                  idx_q   <= 3'd7;
                  tx_q    <= shift_q[7];
               end
               DATA: if (bit_end) begin
                  if (idx_q == 3'd0) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     idx_q <= idx_q - 3'd1;
                     tx_q  <= shift_q[idx_q - 3'd1];
                  end
               end
               STOP: begin
                  // Registered done must rise one clock early to cover the final stop clock.
                  done_q <= (os_d == 4'd15) & tick_nxt;
                  if (bit_end) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: a frame-timing reference model predicts the
// line level, busy, done and ready every clock; a line decoder recovers bytes.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CLK_HZ = 48;
   localparam int BAUD   = 1;
   localparam int BP     = OVERSAMPLE * (CLK_HZ / (BAUD * OVERSAMPLE));
   localparam int FRAME  = 10 * BP;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   logic tx, busy, done;

   uart_tx_if bus();

   uart_tx #(.UART_INPUT_CLK(CLK_HZ), .baud_rate(BAUD)) dut (
      .clk   (clk),
      .arst_n(arst_n),
      .bus   (bus),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a frame is a start time plus a byte; the line level is
   // derived from the clocks elapsed since the start edge.
   int         cyc = 0;
   bit         m_active = 0;
   bit         m_hold_full = 0;
   int         m_start = 0;
   logic [7:0] m_byte = 8'h00;
   logic [7:0] m_hold = 8'h00;
   logic [9:0] exp_q[$];
   logic [9:0] rx_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic exp_line();
      int b;
      if (!m_active) return 1'b1;
      b = (cyc - m_start) / BP;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[8-b];
      return 1'b1;
   endfunction

   task automatic check_outputs();
      int k;
      k = cyc - m_start;
      chk("tx",       32'(tx),           32'(exp_line()));
      chk("busy",     32'(busy),         32'(m_active));
      chk("done",     32'(done),         32'(m_active && k == FRAME - 1));
      chk("tx_ready", 32'(bus.tx_ready), 32'(bus.tx_en && !m_hold_full));
   endtask

   task automatic tick(output bit acc);
      logic [7:0] d;
      d   = bus.tx_data;
      acc = bus.tx_valid && bus.tx_en && !m_hold_full;
      @(posedge clk);
      cyc++;
      if (m_active && cyc == m_start + FRAME) begin
         exp_q.push_back({2'b11, m_byte});
         if (m_hold_full) begin
            m_start = cyc; m_byte = m_hold; m_hold_full = 0;
         end else begin
            m_active = 0;
         end
      end else if (!m_active && m_hold_full) begin
         m_active = 1; m_start = cyc; m_byte = m_hold; m_hold_full = 0;
      end
      if (acc) begin
         m_hold_full = 1; m_hold = d;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run(input int n);
      bit a;
      repeat (n) tick(a);
   endtask

   task automatic send(input logic [7:0] b);
      bit a;
      int guard;
      a = 0; guard = 0;
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      while (!a && guard < 3 * FRAME) begin
         tick(a);
         guard++;
      end
      chk("accept_in_time", 32'(a), 32'd1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_k(input int kk);
      int guard;
      guard = 0;
      while (!(m_active && cyc - m_start >= kk) && guard < 3 * FRAME) begin
         run(1);
         guard++;
      end
      chk("reach_bit_in_time", 32'(m_active && cyc - m_start >= kk), 32'd1);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((m_active || m_hold_full) && guard < 3 * FRAME) begin
         run(1);
         guard++;
      end
      chk("idle_in_time", 32'(m_active || m_hold_full), 32'd0);
      run(2);
   endtask

   // Line decoder: samples mid-bit after a detected falling edge.
   int         rx_cnt;
   logic       rx_busy;
   logic       rx_sok;
   logic [7:0] rx_sh;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rx_busy <= 1'b0;
         rx_cnt  <= 0;
         rx_sok  <= 1'b1;
         rx_sh   <= 8'h00;
      end else if (!rx_busy) begin
         if (tx == 1'b0) begin
            rx_busy <= 1'b1;
            rx_cnt  <= 1;
            rx_sok  <= 1'b1;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt % BP == BP / 2) begin
            case (rx_cnt / BP)
               0: if (tx !== 1'b0) rx_sok <= 1'b0;
               9: begin
                  rx_q.push_back({tx, rx_sok, rx_sh});
                  rx_busy <= 1'b0;
               end
               default: rx_sh <= {rx_sh[6:0], tx};
            endcase
         end
      end
   end

   initial begin
      bus.tx_en    = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      arst_n       = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("rst_tx",    32'(tx),           32'd1);
         chk("rst_busy",  32'(busy),         32'd0);
         chk("rst_done",  32'(done),         32'd0);
         chk("rst_ready", 32'(bus.tx_ready), 32'd1);
      end
      arst_n = 1'b1;
      run(3);

      send(8'hD6);
      wait_idle();

      send(8'hD6);
      send(8'hD4);
      wait_idle();

      bus.tx_en    = 1'b0;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hA5;
      run(2 * BP);
      bus.tx_en = 1'b1;
      send(8'hA5);
      wait_k(4 * BP + BP / 2);
      bus.tx_en = 1'b0;
      wait_idle();
      bus.tx_en = 1'b1;

      send(8'h81);
      wait_k(5 * BP + BP / 2);
      #2 arst_n = 1'b0;
      #2;
      chk("arst_tx",    32'(tx),           32'd1);
      chk("arst_busy",  32'(busy),         32'd0);
      chk("arst_done",  32'(done),         32'd0);
      chk("arst_ready", 32'(bus.tx_ready), 32'd1);
      #1 arst_n = 1'b1;
      m_active    = 0;
      m_hold_full = 0;
      run(BP);
      send(8'h3C);
      wait_idle();

      send(8'h5A);
      send(8'h99);
      bus.tx_data  = 8'h11;
      bus.tx_valid = 1'b1;
      run(3);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h22;
      wait_idle();

      for (int i = 0; i < 12; i++) begin
         int gap;
         gap = $urandom_range(0, 40);
         bus.tx_en = ($urandom_range(0, 3) != 0);
         run(gap);
         bus.tx_en = 1'b1;
         send(8'($urandom));
      end
      wait_idle();
      run(BP);

      chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         chk("rx_frame", 32'(rx_q[i]), 32'(exp_q[i]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
